div_rr_sched: RTL and testbench
===============================

// Module: div_rr_sched
// PURPOSE
// - Shares one iterative unsigned divider among N_REQ requesters via round-robin arbitration.
// - Each requester uses a valid/ready request port; there is one shared response port tagged with the requester id.
// - The FSM sequences one quotient bit per cycle through a single-step divide unit.
// - Sits between client datapaths and the divide resource; it replaces per-client combinational dividers.
// PARAMETERS
// - WIDTH   4  operand, quotient and remainder width in bits (>=2)
// - N_REQ   2  number of requesters (>=2); ID_W = max(1, $clog2(N_REQ))
// PORTS
// - clk        in   1            rising-edge clock
// - rst        in   1            synchronous, active-high reset
// - req_valid  in   N_REQ        per-requester request valid
// - req_ready  out  N_REQ        per-requester accept; at most one bit high per cycle
// - req_x      in   N_REQ*WIDTH  dividends; requester k at [k*WIDTH +: WIDTH]
// - req_y      in   N_REQ*WIDTH  divisors; same packing as req_x
// - rsp_valid  out  1            response valid
// - rsp_ready  in   1            response accept
// - rsp_id     out  ID_W         index of the requester that owns the response
// - rsp_q      out  WIDTH        quotient
// - rsp_r      out  WIDTH        remainder
// - rsp_dbz    out  1            divide-by-zero flag
// - busy       out  1            high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id/q/r=0, rsp_dbz=0, busy=0.
// - FSM states and transitions:
//   - IDLE: if no requester is valid, stay in IDLE.
//   - IDLE: if any requester is valid, ITER, or DONE if y==0.
//   - ITER: run the count WIDTH-1..0; at count 0, go to DONE.
//   - DONE: if rsp_valid && rsp_ready, go to IDLE; otherwise hold.
// - Arbitration (IDLE only): grant the first valid requester at or after rr_ptr, modulo N_REQ.
// - req_ready[g] is asserted combinationally in IDLE for the granted index g only.
// - A transfer happens when req_valid[g] && req_ready[g]. On transfer: latch x, y and id=g; rr_ptr <= (g+1) mod N_REQ.
// - No grant is issued in ITER or DONE; all req_ready bits are 0 in those states.
// - Arithmetic: restoring division, MSB first. Partial remainder P is WIDTH+1 bits and starts at 0.
//   - Per ITER cycle: T = {P[WIDTH-1:0], x[cnt]}.
//   - If T >= y: P = T-y and q bit = 1. Otherwise P = T and q bit = 0.
//   - All arithmetic is unsigned. The final P[WIDTH-1:0] is the remainder.
// - Latency: accept at edge t, so rsp_valid=1 after edge t+WIDTH+1 (WIDTH ITER cycles plus DONE entry).
//   With WIDTH=4 that is 5 edges after the accept edge.
// - Divide-by-zero (y==0): skip ITER. Respond with q=all-ones, r=x, rsp_dbz=1, rsp_valid after edge t+1.
// - rsp_valid, rsp_id, rsp_q, rsp_r and rsp_dbz are registered and held stable while rsp_valid && !rsp_ready.
//   rsp_valid drops on the edge after the handshake.
// - One-cycle bubble: the DONE->IDLE handshake edge cannot grant. The next accept is the following IDLE cycle at the earliest.
// - A requester that deasserts req_valid in IDLE before being granted is not served and is not tracked.
// - x==0: normal path, result q=0, r=0. x<y: q=0, r=x.
// - rst in any state (including mid-ITER or DONE with a pending response) aborts the operation.
//   The in-flight result is discarded and all outputs return to reset values on that edge.
// STRUCTURE
// - Package div_pkg contains:
//   - state typedef {IDLE, ITER, DONE}
//   - DIV_WIDTH_DEF=4
//   - ID_W function
// - Sub-module div_step: combinational single restoring iteration.
//   - Inputs: P, next dividend bit, y.
//   - Outputs: next P, quotient bit.
// - div_rr_sched holds the FSM, the round-robin pointer, the operand/quotient shift registers, the counter and the response registers.
// TESTING (WIDTH=4, N_REQ=2)
// - req0 13/3, rsp_ready=1 -> q=4, r=1, id=0, dbz=0, rsp_valid 5 edges after accept.
// - req1 7/0 -> q=15, r=7, dbz=1, id=1, rsp_valid 1 edge after accept.
// - Both valid after reset, req0 15/1 and req1 3/7:
//   - req0 is served first (q=15, r=0), then req1 (q=0, r=3).
//   - With both held valid, grants alternate 0,1,0,1.
// - 9/2 with rsp_ready=0 for 3 cycles -> rsp_valid and q=4, r=1 stay stable; no req_ready is raised; rsp_valid drops 1 edge after rsp_ready=1.
// - rst for 1 cycle in the 2nd ITER cycle of 14/5 -> all outputs 0 next cycle. A new request 14/5 then gives q=2, r=4.
// - Random sweep of all x,y in 0..15 on both ports against a reference model:
//   - checks q, r and dbz;
//   - checks at most one req_ready bit per cycle;
//   - checks no response is lost or duplicated.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the round-robin shared divider.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } div_state_e;

  function automatic int id_w(input int n_req);
    return (n_req > 2) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/div_rr_sched_if.sv
// Request/response bundle between the client datapaths and the shared divider.
interface div_rr_sched_if #(
  parameter int WIDTH = 4,
  parameter int N_REQ = 2
);
  import div_pkg::*;

  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_q;
  logic [WIDTH-1:0]       rsp_r;
  logic                   rsp_dbz;
  logic                   busy;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, busy
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if possible.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_p,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_p,
  output logic             o_q
);

  logic [WIDTH:0] w_t;

  // The partial remainder is always below y, so only its low WIDTH bits are carried.
  always_comb begin
    w_t = {i_p, i_bit};
    if (w_t >= {1'b0, i_y}) begin
      o_q = 1'b1;
      o_p = WIDTH'(w_t - {1'b0, i_y});
    end else begin
      o_q = 1'b0;
      o_p = w_t[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_rr_sched.sv
// Round-robin scheduler sharing one bit-serial unsigned divider among N_REQ requesters.
module div_rr_sched
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF,
  parameter int N_REQ = 2
) (
  input logic           clk,
  input logic           rst,
  div_rr_sched_if.slave bus
);

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_p;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz;
  logic             r_busy;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_q;
  logic [WIDTH-1:0] r_rsp_r;
  logic             r_rsp_dbz;

  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_x;
  logic [WIDTH-1:0] w_gnt_y;
  logic [N_REQ-1:0] w_req_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_step_p;
  logic             w_step_q;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) begin
      s = s - N_REQ;
    end else begin
      s = s;
    end
    return ID_W'(s);
  endfunction

  // Search for the first valid requester starting at the round-robin pointer.
  always_comb begin
    logic            hit;
    logic [ID_W-1:0] cand;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand      = wrap_idx(r_rr_ptr, k);
      hit       = !w_gnt_vld && bus.req_valid[cand];
      w_gnt_idx = hit ? cand : w_gnt_idx;
      w_gnt_vld = w_gnt_vld | hit;
    end
  end

  assign w_gnt_x = bus.req_x[int'(w_gnt_idx)*WIDTH +: WIDTH];
  assign w_gnt_y = bus.req_y[int'(w_gnt_idx)*WIDTH +: WIDTH];

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_p   (r_p),
    .i_bit (r_x[WIDTH-1]),
    .i_y   (r_y),
    .o_p   (w_step_p),
    .o_q   (w_step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and grant decode; grants are only offered while idle.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_vld) begin
          w_req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << w_gnt_idx;
          w_accept    = 1'b1;
          w_state_nxt = (w_gnt_y == {WIDTH{1'b0}}) ? DONE : ITER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ITER: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = ITER;
        end
      end
      DONE: begin
        if (r_rsp_valid && bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial iteration and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_q         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_dbz   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x      <= w_gnt_x;
            r_y      <= w_gnt_y;
            r_id     <= w_gnt_idx;
            r_rr_ptr <= wrap_idx(w_gnt_idx, 1);
            r_p      <= '0;
            r_q      <= '0;
            r_cnt    <= CNT_W'(WIDTH - 1);
            r_dbz    <= (w_gnt_y == {WIDTH{1'b0}});
          end
        end
        ITER: begin
          r_p   <= w_step_p;
          r_q   <= {r_q[WIDTH-2:0], w_step_q};
          r_x   <= {r_x[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        DONE: begin
          // First DONE cycle publishes the result; a divide-by-zero never shifted x.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_dbz   <= r_dbz;
            r_rsp_q     <= r_dbz ? {WIDTH{1'b1}} : r_q;
            r_rsp_r     <= r_dbz ? r_x : r_p;
          end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_dbz   = r_rsp_dbz;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_div_rr_sched.sv
// Directed and exhaustive-operand bench for div_rr_sched with WIDTH=4, N_REQ=2.
module tb_div_rr_sched;

  localparam int W = 4;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_rr_sched_if #(.WIDTH(W), .N_REQ(N)) bus ();

  div_rr_sched #(.WIDTH(W), .N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int idx; int x; int y; int q; int r; int dbz; int lat;
  } vec_t;

  vec_t vecs[10];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      lat++;
      ok = bus.rsp_valid;
    end
  endtask

  task automatic run_one(input int idx, input int x, input int y, input int q, input int r,
                         input int dbz, input int lat);
    int l;
    bit ok;
    bus.req_valid            = '0;
    bus.req_valid[idx]       = 1'b1;
    bus.req_x[idx*W +: W]    = W'(x);
    bus.req_y[idx*W +: W]    = W'(y);
    bus.rsp_ready            = 1'b1;
    #1;
    check("grant", bus.req_ready, 32'(1) << idx);
    tick();
    bus.req_valid = '0;
    check("busy_after_accept", bus.busy, 1);
    wait_rsp(l, ok);
    check("rsp_timeout", ok, 1);
    check("latency", l, lat);
    check("rsp_q", bus.rsp_q, q);
    check("rsp_r", bus.rsp_r, r);
    check("rsp_dbz", bus.rsp_dbz, dbz);
    check("rsp_id", bus.rsp_id, idx);
    tick();
    check("rsp_drop", bus.rsp_valid, 0);
    check("idle_after_rsp", bus.busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_rsp_q"}, bus.rsp_q, 0);
    check({tag, "_rsp_r"}, bus.rsp_r, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_dbz"}, bus.rsp_dbz, 0);
  endtask

  initial begin
    logic [1:0] acc, got, acc_now;
    bit         multi, bad;
    int         l, x0, y0, x1, y1, j, id, ex, ey;
    bit         ok;

    vecs[0] = '{0, 13, 3,  4, 1, 0, 5};
    vecs[1] = '{1,  7, 0, 15, 7, 1, 1};
    vecs[2] = '{0,  0, 5,  0, 0, 0, 5};
    vecs[3] = '{1,  3, 7,  0, 3, 0, 5};
    vecs[4] = '{0, 15, 1, 15, 0, 0, 5};
    vecs[5] = '{1,  9, 2,  4, 1, 0, 5};
    vecs[6] = '{0, 15, 15, 1, 0, 0, 5};
    vecs[7] = '{1, 14, 5,  2, 4, 0, 5};
    vecs[8] = '{0,  0, 0, 15, 0, 1, 1};
    vecs[9] = '{1, 12, 4,  3, 0, 0, 5};

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Both requesters held valid: grants alternate starting at 0.
    bus.req_x     = {4'd3, 4'd15};
    bus.req_y     = {4'd7, 4'd1};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      check("rr_grant", bus.req_ready, 32'(1) << (g % 2));
      tick();
      wait_rsp(l, ok);
      check("rr_timeout", ok, 1);
      check("rr_id", bus.rsp_id, g % 2);
      check("rr_q", bus.rsp_q, (g % 2 == 0) ? 15 : 0);
      check("rr_r", bus.rsp_r, (g % 2 == 0) ? 0 : 3);
      tick();
    end
    bus.req_valid = '0;

    for (int v = 0; v < 10; v++) begin
      run_one(vecs[v].idx, vecs[v].x, vecs[v].y, vecs[v].q, vecs[v].r, vecs[v].dbz, vecs[v].lat);
    end

    // Response back-pressure: result held, no new grant while stalled.
    bus.rsp_ready     = 1'b0;
    bus.req_x[3:0]    = 4'd9;
    bus.req_y[3:0]    = 4'd2;
    bus.req_valid     = 2'b01;
    #1;
    check("stall_grant", bus.req_ready, 1);
    tick();
    bus.req_valid = '0;
    wait_rsp(l, ok);
    check("stall_timeout", ok, 1);
    bus.req_x[7:4]  = 4'd5;
    bus.req_y[7:4]  = 4'd5;
    bus.req_valid   = 2'b10;
    #1;
    check("stall_no_ready", bus.req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_valid", bus.rsp_valid, 1);
      check("stall_q", bus.rsp_q, 4);
      check("stall_r", bus.rsp_r, 1);
      check("stall_id", bus.rsp_id, 0);
      check("stall_no_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.req_valid = '0;
    check("stall_drop", bus.rsp_valid, 0);
    check("stall_idle", bus.busy, 0);

    // Reset during the second ITER cycle abandons the operation.
    bus.req_x[3:0] = 4'd14;
    bus.req_y[3:0] = 4'd5;
    bus.req_valid  = 2'b01;
    tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    repeat (6) tick();
    check("midrst_no_rsp", bus.rsp_valid, 0);
    run_one(0, 14, 5, 2, 4, 0, 5);

    // All operand pairs on port 0, a permutation of them on port 1, random back-pressure.
    for (int i = 0; i < 256; i++) begin
      j  = (i * 37 + 11) % 256;
      x0 = i / 16; y0 = i % 16;
      x1 = j / 16; y1 = j % 16;
      bus.req_x     = {4'(x1), 4'(x0)};
      bus.req_y     = {4'(y1), 4'(y0)};
      bus.req_valid = 2'b11;
      acc   = '0;
      got   = '0;
      multi = 1'b0;
      bad   = 1'b0;
      for (int c = 0; c < 60 && got != 2'b11; c++) begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        if ($countones(bus.req_ready) > 1) multi = 1'b1;
        acc_now = bus.req_ready & bus.req_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
          id = int'(bus.rsp_id);
          if (!acc[id] || got[id]) begin
            bad = 1'b1;
          end else begin
            ex = (id == 0) ? x0 : x1;
            ey = (id == 0) ? y0 : y1;
            check("sweep_q", bus.rsp_q, (ey == 0) ? 15 : ex / ey);
            check("sweep_r", bus.rsp_r, (ey == 0) ? ex : ex % ey);
            check("sweep_dbz", bus.rsp_dbz, (ey == 0) ? 1 : 0);
            got[id] = 1'b1;
          end
        end
        tick();
        acc           = acc | acc_now;
        bus.req_valid = bus.req_valid & ~acc_now;
      end
      check("sweep_served", got, 2'b11);
      check("sweep_onehot", multi, 0);
      check("sweep_dup_or_unrequested", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
